// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block width, ShiftRows mode encodings and the byte-permutation helper.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam logic [1:0] AES_MODE_PASS = 2'd0;
    localparam logic [1:0] AES_MODE_FWD  = 2'd1;
    localparam logic [1:0] AES_MODE_INV  = 2'd2;

    // Column-major state: byte b is row b%4, column b/4; row r rotates by r columns.
    function automatic logic [AES_BLOCK_W-1:0] aes_shift_rows(input logic [AES_BLOCK_W-1:0] state, input logic inv);
        logic [AES_BLOCK_W-1:0] res;
        int src;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            src = 4 * ((inv ? (b / 4 - b % 4 + 4) : (b / 4 + b % 4)) % 4) + b % 4;
            res[127 - 8 * b -: 8] = state[127 - 8 * src -: 8];
        end
        return res;
    endfunction
endpackage

// File: rtl/aes_shift_rows_comb.sv
// aes_shift_rows_comb: one 128-bit lane of ShiftRows / InvShiftRows / pass, purely combinational.
module aes_shift_rows_comb
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [1:0]             mode,
    output logic [AES_BLOCK_W-1:0] result
);
    always_comb result = (mode == AES_MODE_FWD) ? aes_shift_rows(state, 1'b0) :
                         (mode == AES_MODE_INV) ? aes_shift_rows(state, 1'b1) : state;
endmodule

// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: multi-lane ShiftRows stage followed by an elastic register pipe with
// valid/ready handshaking; empty stages absorb beats while downstream stages are stalled.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AES_BLOCK_W*LANES-1:0] in_data,
    input  logic [1:0]                   in_mode,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AES_BLOCK_W*LANES-1:0] out_data,
    output logic [TAG_W-1:0]             out_tag
);
    localparam int DW   = AES_BLOCK_W * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    logic [DW-1:0]          perm;
    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] valid_d, valid_q;
    logic [DW-1:0]          data_d [PIPE_STAGES];
    logic [DW-1:0]          data_q [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        aes_shift_rows_comb u_comb (
            .state  (in_data[AES_BLOCK_W*l +: AES_BLOCK_W]),
            .mode   (in_mode),
            .result (perm[AES_BLOCK_W*l +: AES_BLOCK_W])
        );
    end

    // A stage loads if it or any stage downstream of it is empty, or the output drains.
    always_comb begin
        logic acc;
        load = '0;
        acc  = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            acc     = acc | ~valid_q[k];
            load[k] = acc;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            if (load[k]) begin
                if (k == 0) begin
                    valid_d[k] = in_valid;
                    data_d[k]  = in_valid ? perm : data_q[k];
                    tag_d[k]   = in_valid ? in_tag : tag_q[k];
                end else begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
                    tag_d[k]   = valid_q[k-1] ? tag_q[k-1] : tag_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
            tag_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb_aes_shift_rows_pipe: directed checks of ShiftRows vectors, handshaking, backpressure, reset and a fwd->inv round trip.
module tb_aes_shift_rows_pipe;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] CNT      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CNT_FWD  = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] CNT_INV  = 128'h000d0a0704010e0b0805020f0c090603;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic         a_iv, a_ir, a_ov, a_or;
    logic [127:0] a_id, a_od;
    logic [1:0]   a_im;
    logic [7:0]   a_it, a_ot;

    logic         b_iv, b_ir, b_ov, b_or;
    logic [127:0] b_id, b_od;
    logic [1:0]   b_im;
    logic [7:0]   b_it, b_ot;

    logic         c_iv, c_ir, m_v, m_r, c_ov, c_or;
    logic [511:0] c_id, m_d, c_od;
    logic [7:0]   c_it, m_t, c_ot;

    aes_shift_rows_pipe #(.LANES(1), .PIPE_STAGES(1), .TAG_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_mode(a_im),
        .in_tag(a_it), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_tag(a_ot));

    aes_shift_rows_pipe #(.LANES(1), .PIPE_STAGES(3), .TAG_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_mode(b_im),
        .in_tag(b_it), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_tag(b_ot));

    aes_shift_rows_pipe #(.LANES(4), .PIPE_STAGES(3), .TAG_W(8)) u_fwd (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_mode(2'd1),
        .in_tag(c_it), .out_valid(m_v), .out_ready(m_r), .out_data(m_d), .out_tag(m_t));

    aes_shift_rows_pipe #(.LANES(4), .PIPE_STAGES(3), .TAG_W(8)) u_inv (
        .clk(clk), .rst(rst), .in_valid(m_v), .in_ready(m_r), .in_data(m_d), .in_mode(2'd2),
        .in_tag(m_t), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_tag(c_ot));

    task automatic chk(input string nm, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [511:0] q_d[$];
    logic [7:0]   q_t[$];

    initial begin
        logic [1:0]   modes [8];
        logic [127:0] exp_d, held_d;
        logic [7:0]   held_t, tg;
        logic         stalled;
        int acc, outs, sent, rcvd, cyc, first_acc;
        modes = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
        a_iv = 0; a_id = '0; a_im = 0; a_it = 0; a_or = 1;
        b_iv = 0; b_id = '0; b_im = 0; b_it = 0; b_or = 1;
        c_iv = 0; c_id = '0; c_it = 0; c_or = 1;
        repeat (2) tick();
        rst = 0;
        #1;
        chk("rst_a_out_valid", a_ov, 1'b0);
        chk("rst_a_in_ready", a_ir, 1'b1);
        chk("rst_a_out_data", a_od, '0);
        chk("rst_a_out_tag", a_ot, '0);
        chk("rst_b_out_valid", b_ov, 1'b0);
        chk("rst_b_in_ready", b_ir, 1'b1);

        // FIPS-197 round 1 vector, one-cycle latency
        a_iv = 1; a_id = FIPS_IN; a_im = 2'd1; a_it = 8'h5a;
        tick();
        a_iv = 0;
        chk("fips_valid", a_ov, 1'b1);
        chk("fips_data", a_od, FIPS_OUT);
        chk("fips_tag", a_ot, 8'h5a);
        tick();
        chk("fips_drained", a_ov, 1'b0);

        // Back-to-back beats with per-beat mode changes on the counting pattern
        for (int i = 0; i < 8; i++) begin
            a_iv = 1; a_id = CNT; a_im = modes[i]; a_it = 8'(i);
            #1;
            chk("b2b_in_ready", a_ir, 1'b1);
            tick();
            exp_d = (modes[i] == 2'd1) ? CNT_FWD : (modes[i] == 2'd2) ? CNT_INV : CNT;
            chk("b2b_valid", a_ov, 1'b1);
            chk("b2b_data", a_od, exp_d);
            chk("b2b_tag", a_ot, 8'(i));
        end
        a_iv = 0;
        tick();
        chk("b2b_idle", a_ov, 1'b0);

        // Stall on a full single-stage pipe, then drain and accept in the same cycle
        a_or = 0; a_iv = 1; a_id = CNT; a_im = 2'd1; a_it = 8'h77;
        tick();
        a_id = CNT; a_im = 2'd2; a_it = 8'h88;
        #1;
        chk("stall_in_ready", a_ir, 1'b0);
        tick();
        chk("stall_valid", a_ov, 1'b1);
        chk("stall_data", a_od, CNT_FWD);
        chk("stall_tag", a_ot, 8'h77);
        a_or = 1;
        #1;
        chk("unstall_in_ready", a_ir, 1'b1);
        tick();
        a_iv = 0;
        chk("swap_data", a_od, CNT_INV);
        chk("swap_tag", a_ot, 8'h88);

        // Three-stage pipe fills with exactly three beats under full backpressure
        b_or = 0; b_iv = 1; b_im = 2'd0; acc = 0; tg = 0;
        for (int i = 0; i < 8; i++) begin
            b_id = {$urandom(), $urandom(), $urandom(), $urandom()}; b_it = tg;
            #1;
            if (!b_ir) break;
            q_d.push_back(512'(b_id)); q_t.push_back(b_it); tg++; acc++;
            tick();
        end
        chk("bp_fill_count", acc, 3);
        chk("bp_fill_valid", b_ov, 1'b1);

        // Random backpressure: ordering, no loss/duplication, stable output under stall
        stalled = 0; held_d = '0; held_t = '0;
        for (int i = 0; i < 400; i++) begin
            b_or = 1'($urandom_range(0, 1));
            b_id = {$urandom(), $urandom(), $urandom(), $urandom()}; b_it = tg;
            #1;
            if (stalled) begin
                chk("bp_hold_valid", b_ov, 1'b1);
                chk("bp_hold_data", b_od, held_d);
                chk("bp_hold_tag", b_ot, held_t);
            end
            if (b_ir) begin
                q_d.push_back(512'(b_id)); q_t.push_back(b_it); tg++;
            end
            if (b_ov && b_or) begin
                chk("bp_nonempty", q_d.size() > 0, 1'b1);
                if (q_d.size() > 0) begin
                    chk("bp_data", b_od, q_d.pop_front());
                    chk("bp_tag", b_ot, q_t.pop_front());
                end
            end
            stalled = b_ov && !b_or; held_d = b_od; held_t = b_ot;
            tick();
        end
        b_iv = 0; b_or = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b_ov && q_d.size() > 0) begin
                chk("bp_drain_data", b_od, q_d.pop_front());
                chk("bp_drain_tag", b_ot, q_t.pop_front());
            end
            tick();
        end
        chk("bp_queue_empty", q_d.size(), 0);
        chk("bp_drained_valid", b_ov, 1'b0);

        // Reset with three beats in flight
        b_or = 0; b_iv = 1;
        for (int i = 0; i < 3; i++) begin
            b_id = CNT; b_it = 8'(8'hf0 + i);
            #1;
            chk("rstf_accept", b_ir, 1'b1);
            tick();
        end
        rst = 1; b_it = 8'hf3;
        tick();
        rst = 0; b_iv = 0;
        #1;
        chk("rstf_out_valid", b_ov, 1'b0);
        chk("rstf_in_ready", b_ir, 1'b1);
        chk("rstf_out_data", b_od, '0);
        b_or = 1; outs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_ov) outs++;
        end
        chk("rstf_no_output", outs, 0);

        // Round trip fwd -> inv, four lanes, 1000 beats
        sent = 0; rcvd = 0; cyc = 0; first_acc = -1;
        while (rcvd < 1000 && cyc < 1500) begin
            c_iv = (sent < 1000);
            for (int w = 0; w < 16; w++) c_id[32*w +: 32] = $urandom();
            c_it = 8'($urandom());
            #1;
            if (c_iv && c_ir) begin
                if (sent == 0) first_acc = cyc;
                q_d.push_back(c_id); q_t.push_back(c_it); sent++;
            end
            if (c_ov && c_or) begin
                if (rcvd == 0) chk("rt_first_latency", cyc - first_acc, 6);
                if (q_d.size() > 0) begin
                    chk("rt_data", c_od, q_d.pop_front());
                    chk("rt_tag", c_ot, q_t.pop_front());
                end else chk("rt_nonempty", 1'b0, 1'b1);
                rcvd++;
            end
            tick();
            cyc++;
        end
        c_iv = 0;
        chk("rt_received", rcvd, 1000);
        chk("rt_cycles", cyc, 1006);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
